// File: rtl/decode_stage.sv
// Y86-64 decode/write-back stage: register file, operand source/destination select,
// E/M/W forwarding and the E pipeline register. Optional FWD_STATS_EN adds forwarding counters.
module decode_stage #(
    parameter int XLEN    = 64,
    parameter int NREG    = 15,
    parameter int RSP_IDX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [3:0]      D_rA,
    input  logic [3:0]      D_rB,
    input  logic [XLEN-1:0] D_valC,
    input  logic [XLEN-1:0] D_valP,
    input  logic [3:0]      D_stat,
    input  logic            E_bubble,
    input  logic [3:0]      e_dstE,
    input  logic [XLEN-1:0] e_valE,
    input  logic [3:0]      M_dstE,
    input  logic [3:0]      M_dstM,
    input  logic [XLEN-1:0] M_valE,
    input  logic [XLEN-1:0] m_valM,
    input  logic [3:0]      W_dstE,
    input  logic [3:0]      W_dstM,
    input  logic [XLEN-1:0] W_valE,
    input  logic [XLEN-1:0] W_valM,
    output logic [3:0]      d_srcA,
    output logic [3:0]      d_srcB,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [XLEN-1:0] E_valC,
    output logic [XLEN-1:0] E_valA,
    output logic [XLEN-1:0] E_valB,
    output logic [3:0]      E_dstE,
    output logic [3:0]      E_dstM,
    output logic [3:0]      E_srcA,
    output logic [3:0]      E_srcB,
    output logic [3:0]      E_stat
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]     fwd_cnt,
    output logic [31:0]     rf_cnt
`endif
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = RSP_IDX[3:0];
    localparam logic [3:0] SAOK  = 4'b1000;

    logic [XLEN-1:0] rf [NREG];
    logic [3:0]      src_a, src_b, dst_e, dst_m;
    logic [XLEN-1:0] val_a, val_b;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            4'h2: begin src_a = D_rA; dst_e = D_rB; end
            4'h3: dst_e = D_rB;
            4'h4: begin src_a = D_rA; src_b = D_rB; end
            4'h5: begin src_b = D_rB; dst_m = D_rA; end
            4'h6: begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            4'h8: begin src_b = RSP; dst_e = RSP; end
            4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            4'hA: begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
            4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
            default: ;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    // Youngest producer wins; RNONE is excluded up front so it never matches an idle stage.
    function automatic logic [XLEN-1:0] operand(input logic [3:0] src);
        if (src == RNONE)       return '0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return rf[src];
    endfunction

    always_comb begin
        val_a = operand(src_a);
        if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
        val_b = operand(src_b);
    end

    // W_dstM is written last so popq %rsp keeps the popped value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (W_dstE != RNONE) rf[W_dstE] <= W_valE;
            if (W_dstM != RNONE) rf[W_dstM] <= W_valM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || E_bubble) begin
            E_icode <= 4'h1;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
            E_stat  <= SAOK;
        end else begin
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= val_a;
            E_valB  <= val_b;
            E_dstE  <= dst_e;
            E_dstM  <= dst_m;
            E_srcA  <= src_a;
            E_srcB  <= src_b;
            E_stat  <= D_stat;
        end
    end

`ifdef FWD_STATS_EN
    function automatic logic fwd_hit(input logic [3:0] src);
        return (src != RNONE) && (src == e_dstE || src == M_dstM || src == M_dstE ||
                                  src == W_dstM || src == W_dstE);
    endfunction

    logic hit_a, hit_b, use_a, use_b;
    assign hit_a = fwd_hit(src_a);
    assign hit_b = fwd_hit(src_b);
    assign use_a = (src_a != RNONE) && !hit_a;
    assign use_b = (src_b != RNONE) && !hit_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt <= '0;
            rf_cnt  <= '0;
        end else if (!E_bubble) begin
            fwd_cnt <= fwd_cnt + 32'(hit_a) + 32'(hit_b);
            rf_cnt  <= rf_cnt + 32'(use_a) + 32'(use_b);
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, multi-cycle sequences and a randomized
// run against a set-membership / priority-list reference model.
module tb_decode_stage;
    localparam logic [3:0] F = 4'hF;

    logic        clk;
    logic        rst, E_bubble;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_stat;
    logic [63:0] E_valC, E_valA, E_valB;
`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt, rf_cnt;
`endif

    decode_stage dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_valE(M_valE), .m_valM(m_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
        .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA),
        .E_srcB(E_srcB), .E_stat(E_stat)
`ifdef FWD_STATS_EN
        , .fwd_cnt(fwd_cnt), .rf_cnt(rf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] rf_m [15];
    int unsigned mf = 0, mr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: instruction classes as sets, forwarding as an ordered producer list.
    function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return F;
    endfunction
    function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return F;
    endfunction
    function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return F;
    endfunction
    function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : F;
    endfunction

    task automatic lookup(input logic [3:0] s, output logic [63:0] v, output bit hit);
        logic [3:0]  d [5];
        logic [63:0] pv [5];
        d  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        pv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        hit = 0;
        v = 64'd0;
        if (s == F) return;
        for (int k = 0; k < 5; k++) begin
            if (d[k] == s) begin v = pv[k]; hit = 1; return; end
        end
        v = rf_m[s];
    endtask

    task automatic idle();
        rst = 0; E_bubble = 0;
        D_icode = 4'h1; D_ifun = 0; D_rA = F; D_rB = F; D_stat = 4'b1000;
        D_valC = 64'h77; D_valP = 0;
        e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    // One clock: inputs already driven; check comb sources, clock, check E against the model.
    task automatic cycle();
        logic [3:0] sa, sb, de, dm, x_ic, x_if, x_st;
        logic [63:0] va, vb, vc;
        bit ha, hb, nop;
        #1;
        sa = m_srca(D_icode, D_rA);
        sb = m_srcb(D_icode, D_rB);
        de = m_dste(D_icode, D_rB);
        dm = m_dstm(D_icode, D_rA);
        lookup(sa, va, ha);
        lookup(sb, vb, hb);
        if (D_icode inside {4'h7, 4'h8}) va = D_valP;
        chk("d_srcA", d_srcA, sa);
        chk("d_srcB", d_srcB, sb);
        nop = rst || E_bubble;
        x_ic = D_icode; x_if = D_ifun; x_st = D_stat; vc = D_valC;
        if (nop) begin
            x_ic = 4'h1; x_if = 0; x_st = 4'b1000; vc = 0; va = 0; vb = 0;
            sa = F; sb = F; de = F; dm = F;
        end
        @(posedge clk); #1;
        chk("E_icode", E_icode, x_ic);
        chk("E_ifun", E_ifun, x_if);
        chk("E_valC", E_valC, vc);
        chk("E_valA", E_valA, va);
        chk("E_valB", E_valB, vb);
        chk("E_dstE", E_dstE, de);
        chk("E_dstM", E_dstM, dm);
        chk("E_srcA", E_srcA, sa);
        chk("E_srcB", E_srcB, sb);
        chk("E_stat", E_stat, x_st);
        if (rst) begin
            foreach (rf_m[k]) rf_m[k] = 0;
            mf = 0; mr = 0;
        end else begin
            if (W_dstE != F) rf_m[W_dstE] = W_valE;
            if (W_dstM != F) rf_m[W_dstM] = W_valM;
            if (!E_bubble) begin
                if (sa != F) begin if (ha) mf++; else mr++; end
                if (sb != F) begin if (hb) mf++; else mr++; end
            end
        end
`ifdef FWD_STATS_EN
        chk("fwd_cnt", fwd_cnt, 64'(mf));
        chk("rf_cnt", rf_cnt, 64'(mr));
`endif
    endtask

    typedef struct {
        bit rst, bub;
        logic [3:0] ic, ra, rb, st;
        logic [63:0] vp;
        logic [3:0] ed, md, mm, wd, wm;
        logic [63:0] ev, mv, mmv, wv, wmv;
        logic [3:0] x_ic, x_de, x_dm, x_sa, x_sb, x_st;
        logic [63:0] x_va, x_vb;
    } vec_t;

    vec_t tv [12];
    vec_t dv;

    initial begin
        dv = '{rst:0, bub:0, ic:4'h1, ra:F, rb:F, st:4'b1000, vp:0,
               ed:F, md:F, mm:F, wd:F, wm:F, ev:0, mv:0, mmv:0, wv:0, wmv:0,
               x_ic:4'h1, x_de:F, x_dm:F, x_sa:F, x_sb:F, x_st:4'b1000, x_va:0, x_vb:0};
        foreach (tv[k]) tv[k] = dv;
        tv[0].rst = 1; tv[0].ic = 4'h6; tv[0].ra = 1; tv[0].rb = 2;
        tv[1].wd = 3; tv[1].wv = 64'h2A;
        tv[2].ic = 4'h6; tv[2].ra = 3; tv[2].rb = 3;
        tv[2].x_ic = 4'h6; tv[2].x_va = 64'h2A; tv[2].x_vb = 64'h2A; tv[2].x_de = 3; tv[2].x_sa = 3; tv[2].x_sb = 3;
        tv[3].ic = 4'h2; tv[3].ra = 2; tv[3].rb = 5; tv[3].ed = 2; tv[3].ev = 5;
        tv[3].md = 2; tv[3].mv = 7; tv[3].wd = 2; tv[3].wv = 9;
        tv[3].x_ic = 4'h2; tv[3].x_va = 5; tv[3].x_de = 5; tv[3].x_sa = 2;
        tv[4].ic = 4'h6; tv[4].ra = 2; tv[4].rb = 0;
        tv[4].x_ic = 4'h6; tv[4].x_va = 9; tv[4].x_de = 0; tv[4].x_sa = 2; tv[4].x_sb = 0;
        tv[5].ic = 4'h8; tv[5].vp = 64'h40;
        tv[5].x_ic = 4'h8; tv[5].x_va = 64'h40; tv[5].x_sb = 4; tv[5].x_de = 4;
        tv[6].ic = 4'hB; tv[6].ra = 4; tv[6].wd = 4; tv[6].wv = 64'h100; tv[6].wm = 4; tv[6].wmv = 64'h200;
        tv[6].x_ic = 4'hB; tv[6].x_va = 64'h200; tv[6].x_vb = 64'h200; tv[6].x_sa = 4; tv[6].x_sb = 4;
        tv[6].x_de = 4; tv[6].x_dm = 4;
        tv[7].ic = 4'h6; tv[7].ra = 4; tv[7].rb = 4;
        tv[7].x_ic = 4'h6; tv[7].x_va = 64'h200; tv[7].x_vb = 64'h200; tv[7].x_sa = 4; tv[7].x_sb = 4; tv[7].x_de = 4;
        tv[8].bub = 1; tv[8].ic = 4'h3; tv[8].rb = 1;
        tv[9].ic = 4'hC; tv[9].ra = 1; tv[9].rb = 1; tv[9].st = 4'b0001;
        tv[9].x_ic = 4'hC; tv[9].x_st = 4'b0001;
        tv[10].ic = 4'h4; tv[10].ra = 7; tv[10].rb = 7; tv[10].mm = 7; tv[10].mmv = 64'hAA;
        tv[10].md = 7; tv[10].mv = 64'hBB;
        tv[10].x_ic = 4'h4; tv[10].x_va = 64'hAA; tv[10].x_vb = 64'hAA; tv[10].x_sa = 7; tv[10].x_sb = 7;
        tv[11].ic = 4'h5; tv[11].ra = 6; tv[11].rb = 7; tv[11].st = 4'b0010;
        tv[11].x_ic = 4'h5; tv[11].x_sb = 7; tv[11].x_dm = 6; tv[11].x_st = 4'b0010;

        foreach (rf_m[k]) rf_m[k] = 0;
        idle();
        @(posedge clk); #1;
        rst = 1;
        cycle();
        chk("reset E_icode", E_icode, 4'h1);
        chk("reset E_stat", E_stat, 4'b1000);
        chk("reset E_dstE", E_dstE, F);
        rst = 0;
        for (int i = 0; i < 15; i++) begin
            D_icode = 4'h6; D_rA = 4'(i); D_rB = 4'(i);
            cycle();
            chk("reset rf zero", E_valA | E_valB, 0);
        end

        for (int i = 0; i < 12; i++) begin
            idle();
            rst = tv[i].rst; E_bubble = tv[i].bub;
            D_icode = tv[i].ic; D_rA = tv[i].ra; D_rB = tv[i].rb; D_stat = tv[i].st; D_valP = tv[i].vp;
            e_dstE = tv[i].ed; e_valE = tv[i].ev; M_dstE = tv[i].md; M_valE = tv[i].mv;
            M_dstM = tv[i].mm; m_valM = tv[i].mmv;
            W_dstE = tv[i].wd; W_valE = tv[i].wv; W_dstM = tv[i].wm; W_valM = tv[i].wmv;
            cycle();
            chk($sformatf("vec%0d E_icode", i), E_icode, tv[i].x_ic);
            chk($sformatf("vec%0d E_valA", i), E_valA, tv[i].x_va);
            chk($sformatf("vec%0d E_valB", i), E_valB, tv[i].x_vb);
            chk($sformatf("vec%0d E_dstE", i), E_dstE, tv[i].x_de);
            chk($sformatf("vec%0d E_dstM", i), E_dstM, tv[i].x_dm);
            chk($sformatf("vec%0d E_srcA", i), E_srcA, tv[i].x_sa);
            chk($sformatf("vec%0d E_srcB", i), E_srcB, tv[i].x_sb);
            chk($sformatf("vec%0d E_stat", i), E_stat, tv[i].x_st);
        end

        // Write during reset must be dropped: rf[9] stays 0 afterwards.
        idle(); rst = 1; W_dstE = 9; W_valE = 64'h55; W_dstM = 9; W_valM = 64'h66;
        cycle();
        idle(); D_icode = 4'h6; D_rA = 9; D_rB = 9;
        cycle();
        chk("reset write suppressed", E_valA, 0);

        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom_range(0, 15));
            D_rA = 4'($urandom_range(0, 15)); D_rB = 4'($urandom_range(0, 15));
            D_stat = 4'(1 << $urandom_range(0, 3));
            D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
            e_dstE = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : F;
            M_dstE = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : F;
            M_dstM = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : F;
            W_dstE = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 14)) : F;
            W_dstM = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : F;
            e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
            m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
